// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M sequencer (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// A shift-add multiplier and a restoring divider share one adder and one
// pair of working registers (acc, opb). Operands are reduced to magnitudes on
// issue, and the sign is re-applied when the result is loaded.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous reset, active-high despite the name (1 = in reset)
//   start     - M-extension instruction present this cycle
//   funct3    - operation select
//   rs1_data  - operand A / dividend
//   rs2_data  - operand B / divisor
//   stall     - combinational; freezes PC and suppresses RegWrite while busy
//   done      - registered; result valid for exactly one cycle
//   result    - registered result, held until the next load
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned AW = XLEN + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      op, op_nxt;
  logic            neg, neg_nxt;
  logic [XLEN-1:0] opb, opb_nxt;
  logic [PW-1:0]   acc, acc_nxt;
  logic            done_nxt;
  logic [XLEN-1:0] result_nxt;

  // Operand decode at issue
  logic            a_signed, b_signed, a_neg, b_neg, sign_flag;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;

  always_comb begin
    a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
    b_signed  = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    a_neg     = a_signed && rs1_data[XLEN-1];
    b_neg     = b_signed && rs2_data[XLEN-1];
    a_mag     = a_neg ? (~rs1_data + XLEN'(1)) : rs1_data;
    b_mag     = b_neg ? (~rs2_data + XLEN'(1)) : rs2_data;
    // Remainder takes the dividend's sign; everything else the xor of both
    sign_flag = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero  = (rs2_data == '0);
    div_ovf   = !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
  end

  // Shared adder: MUL adds B into the high half; DIV trial-subtracts B from
  // the left-shifted remainder, where carry-out means "no borrow"
  logic [XLEN:0]   add_a, add_b, div_shift, mul_hi;
  logic            add_cin;
  logic [AW-1:0]   sum;
  logic [PW-1:0]   step;

  always_comb begin
    div_shift = acc[PW-1:XLEN-1];
    add_a     = (state == S_DIV) ? div_shift : {1'b0, acc[PW-1:XLEN]};
    add_b     = (state == S_DIV) ? ~{1'b0, opb} : {1'b0, opb};
    add_cin   = (state == S_DIV);
    sum       = {1'b0, add_a} + {1'b0, add_b} + AW'(add_cin);
    mul_hi    = acc[0] ? sum[XLEN:0] : {1'b0, acc[PW-1:XLEN]};
    if (state == S_DIV) begin
      step = {(sum[XLEN+1] ? sum[XLEN-1:0] : div_shift[XLEN-1:0]),
              acc[XLEN-2:0], sum[XLEN+1]};
    end else begin
      step = {mul_hi, acc[XLEN-1:1]};
    end
  end

  // Final sign fix-up and half / quotient / remainder select
  logic [PW-1:0]   prod_fin;
  logic [XLEN-1:0] div_sel, div_fin, fin;

  always_comb begin
    prod_fin = neg ? (~step + PW'(1)) : step;
    div_sel  = op[1] ? step[PW-1:XLEN] : step[XLEN-1:0];
    div_fin  = neg ? (~div_sel + XLEN'(1)) : div_sel;
    if (op[2]) begin
      fin = div_fin;
    end else if (op[1:0] == 2'b00) begin
      fin = prod_fin[XLEN-1:0];
    end else begin
      fin = prod_fin[PW-1:XLEN];
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_nxt     = op;
    neg_nxt    = neg;
    opb_nxt    = opb;
    acc_nxt    = acc;
    done_nxt   = 1'b0;
    result_nxt = result;
    stall      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          stall  = 1'b1;
          op_nxt = funct3;
          if (funct3[2] && div_zero) begin
            state_nxt  = S_DONE;
            done_nxt   = 1'b1;
            result_nxt = funct3[1] ? rs1_data : '1;
          end else if (funct3[2] && div_ovf) begin
            state_nxt  = S_DONE;
            done_nxt   = 1'b1;
            result_nxt = funct3[1] ? '0 : MIN_NEG;
          end else begin
            neg_nxt   = sign_flag;
            opb_nxt   = b_mag;
            acc_nxt   = {XLEN'(0), a_mag};
            cnt_nxt   = CW'(XLEN);
            state_nxt = funct3[2] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        stall   = 1'b1;
        acc_nxt = step;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt  = S_DONE;
          done_nxt   = 1'b1;
          result_nxt = fin;
        end
      end
      S_DONE: begin
        // start is still the same instruction here; ignore it
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op     <= '0;
      neg    <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      op     <= op_nxt;
      neg    <= neg_nxt;
      opb    <= opb_nxt;
      acc    <= acc_nxt;
      done   <= done_nxt;
      result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed bench for muldiv_seq against a
// plain-arithmetic RV32M reference model.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [31:0] last_exp;

  muldiv_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // RV32M semantics from 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      3'd0: p = ua * ub;
      3'd1: p = 64'(sa * sb) >> 32;
      3'd2: p = 64'(sa * longint'(ub)) >> 32;
      3'd3: p = (ua * ub) >> 32;
      3'd4: p = (b == 0) ? 64'hFFFF_FFFF : (ovf ? {32'd0, a} : 64'(sa / sb));
      3'd5: p = (b == 0) ? 64'hFFFF_FFFF : (ua / ub);
      3'd6: p = (b == 0) ? {32'd0, a} : (ovf ? 64'd0 : 64'(sa % sb));
      default: p = (b == 0) ? {32'd0, a} : (ua % ub);
    endcase
    return p[31:0];
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one instruction and observe cycles 0..expected latency
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int          exp_lat;
    int          n_stall;
    int          n_done;
    int          done_cyc;
    logic [31:0] res;
    logic [31:0] exp;
    exp      = ref_op(f3, a, b);
    exp_lat  = is_special(f3, a, b) ? 1 : 33;
    n_stall  = 0;
    n_done   = 0;
    done_cyc = -1;
    res      = '0;
    for (int c = 0; c <= exp_lat; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
      end else if (!hold) begin
        start    = 1'($urandom_range(0, 1));
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
      end
      #1;
      if (stall) n_stall++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res      = result;
        end
      end
    end
    check_eq($sformatf("latency f3=%0d a=%h b=%h", f3, a, b), 32'(done_cyc), 32'(exp_lat));
    check_eq($sformatf("stall_cycles f3=%0d", f3), 32'(n_stall), 32'(exp_lat));
    check_eq($sformatf("done_count f3=%0d", f3), 32'(n_done), 32'd1);
    check_eq($sformatf("result f3=%0d a=%h b=%h", f3, a, b), res, exp);
    last_exp = exp;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check_eq("idle_stall_done", {30'd0, stall, done}, 32'd0);
      check_eq("result_hold", result, last_exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_exp = '0;
    rst_n    = 1'b1;
    start    = 1'b0;
    funct3   = 3'd0;
    rs1_data = '0;
    rs2_data = '0;

    // Reset state, including across clock edges while held
    #2;
    check_eq("reset_outputs", {30'd0, stall, done}, 32'd0);
    check_eq("reset_result", result, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("reset_held_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // Directed cases
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    idle_cycles(1);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(3'd5, 32'd100, 32'd7, 1'b0);
    do_op(3'd7, 32'd100, 32'd7, 1'b0);
    do_op(3'd5, 32'd5, 32'd0, 1'b0);
    do_op(3'd6, 32'd5, 32'd0, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle_cycles(2);

    // Randomized operations
    for (int i = 0; i < 48; i++) begin
      do_op(3'($urandom), rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end
    idle_cycles(1);

    // Known nonzero result, then asynchronous reset in cycle 10 of a DIV
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; rs1_data = 32'hFFFF_FFF9; rs2_data = 32'd2;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check_eq("busy_before_reset", {31'd0, stall}, 32'd1);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("async_reset_outputs", {30'd0, stall, done}, 32'd0);
    check_eq("async_reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    last_exp = 32'd0;
    idle_cycles(2);
    do_op(3'd0, 32'd3, 32'd4, 1'b0);

    // start held through DONE, then back-to-back issue
    idle_cycles(1);
    do_op(3'd0, 32'd3, 32'd4, 1'b1);
    do_op(3'd0, 32'd2, 32'd5, 1'b0);
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the main ALU in the single-cycle core. The main decoder raises start when it sees opcode 0110011 with funct7=0000001.
- The block holds the PC and register-file write through stall until the result is ready, then presents result with done for exactly one cycle.
- It sequences an iterative shift-add multiplier and a restoring divider that share one adder and one pair of working registers.

Parameters:
- XLEN, 32, operand/result width; iteration count per normal operation.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-high (1 = in reset)
- start  input  1  M-extension instruction present this cycle
- funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  input  XLEN  operand A / dividend
- rs2_data  input  XLEN  operand B / divisor
- stall  output  1  freeze PC and suppress RegWrite
- done  output  1  result valid; core writes rd and advances PC this cycle
- result  output  XLEN  registered result

Behaviour:
- Reset (async, any state): state=IDLE; stall=0, done=0, result=0; counter, operand and accumulator registers cleared. Reset mid-operation aborts with no result.
- States: IDLE, MUL, DIV, DONE.
- stall is combinational: stall = (IDLE & start) | MUL | DIV. It is 0 in DONE.
- done is registered: done = (state==DONE).
- IDLE & start, normal case:
  - Latch funct3.
  - Latch magnitudes of the operands per signedness: MULH/DIV/REM treat both operands as signed; MULHSU treats only rs1 as signed; MUL/MULHU/DIVU/REMU treat both as unsigned.
  - Latch the result-sign flag. Mul: sign(A) xor sign(B). DIV: sign(A) xor sign(B). REM: sign(A).
  - Counter = XLEN; go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- IDLE & start, special division cases: skip to DONE on the next edge, so latency is 1 cycle.
  - Divisor = 0: DIV/DIVU give all ones; REM/REMU give rs1_data.
  - Signed overflow (DIV/REM, rs1 = 0x80000000, rs2 = all ones): DIV gives 0x80000000; REM gives 0.
- MUL: one shift-add step per cycle on a 2*XLEN product. Counter decrements; at counter=1 go to DONE.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). Counter decrements; at counter=1 go to DONE.
- Latency: start seen in cycle 0; MUL/DIV occupy cycles 1..XLEN; DONE in cycle XLEN+1. stall is high for cycles 0..XLEN.
- On the transition into DONE, result is loaded:
  - Negate the 2*XLEN product or the quotient/remainder if the sign flag is set.
  - MUL selects the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits; DIV(U) selects the quotient; REM(U) selects the remainder.
- DONE: unconditionally go to IDLE. start is ignored here, because the same instruction is still decoded.
- result holds its value until the next result load.
- start while in MUL/DIV is ignored; operands are already latched. Input changes during busy states have no effect.
- Back-to-back: a new start in the cycle after DONE is accepted normally.
- All arithmetic is modulo 2^(2*XLEN) internally. Magnitude of the most negative value = 2^(XLEN-1), held unsigned.

Test Plan:
- Reset, then MUL rs1=7, rs2=0xFFFFFFFD (-3) -> stall high cycles 0..32, done=1 at cycle 33 only, result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> result 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each completes at cycle 33.
- DIVU 5/0 -> done at cycle 1, result 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1. REM with the same operands -> 0.
- Assert rst_n=1 asynchronously at cycle 10 of a DIV -> stall, done and result go to 0 immediately with no clock edge. After release, a MUL 3x4 gives 12 at cycle 33.
- Hold start high through DONE, then issue a second MUL 2x5 in the next cycle -> exactly one done per instruction, results 12 then 10, no extra operation started.
